fetch_pc_predictor: RTL and testbench
=====================================

Name: fetch_pc_predictor

Overview:
IF-stage front end. Holds the program counter and a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. Each cycle it produces PC, PC_plus_four and PredictJump for the IF/ID pipeline register, and PC also addresses instruction memory. Branch and jump outcomes resolved in EX train the BTB, and an EX redirect overrides the fetch path.

Parameters:
RESET_PC, 32'h00003000, PC value loaded on reset; bits [1:0] must be 0.
BTB_IDX_BITS, 4, log2 of the BTB entry count (default 16 entries).

Ports:
CLK  in  1  rising-edge clock
CLR  in  1  synchronous, active-high reset
PCEn  in  1  1 = advance PC; 0 = hold PC (stall)
Redirect  in  1  EX mispredict/flush; load RedirectPC
RedirectPC  in  32  corrected fetch address
Upd_Valid  in  1  a resolved control-flow instruction is in EX this cycle
Upd_PC  in  32  PC of the resolved instruction
Upd_Taken  in  1  resolved direction
Upd_Target  in  32  resolved target
PC  out  32  current fetch address
PC_plus_four  out  32  PC+4
PredictJump  out  1  BTB predicts taken for the current PC
PredictTarget  out  32  predicted target (valid when PredictJump=1)
FetchCount  out  32  perf counter (see Optional Feature)
RedirectCount  out  32  perf counter (see Optional Feature)

Behaviour:
- Interface: one clock, CLK; reset CLR is synchronous and active-high.
- Reset (CLR=1 at edge):
  - PC=RESET_PC.
  - All BTB valid bits cleared; all counters set to 2'b01.
  - Resulting outputs: PC_plus_four=RESET_PC+4, PredictJump=0.
  - CLR overrides every other input, including updates in the same cycle.
- PC_plus_four is combinational PC+4, modulo 2^32; 32'hFFFFFFFC wraps to 0.
- Lookup (combinational, on PC):
  - idx = PC[BTB_IDX_BITS+1:2]; tag = PC[31:BTB_IDX_BITS+2].
  - hit = valid[idx] && tag match.
  - PredictJump = hit && ctr[idx][1].
  - PredictTarget = target[idx] on a hit, else 0.
- Next-PC priority at each edge: CLR > Redirect > !PCEn (hold) > PredictJump ? PredictTarget : PC+4.
  - Redirect loads {RedirectPC[31:2],2'b00} even when PCEn=0.
  - Latency: redirect or prediction takes effect on PC one cycle later.
- BTB update on Upd_Valid (independent of PCEn and Redirect), entry selected by Upd_PC:
  - Hit: counter increments if Upd_Taken, else decrements; saturates at 2'b11 and 2'b00. If Upd_Taken, target := {Upd_Target[31:2],2'b00}.
  - Miss and Upd_Taken: allocate (overwrite) the entry: valid=1, tag, target, counter=2'b10.
  - Miss and not taken: no change.
- Same-cycle lookup and update at the same index: the lookup sees the pre-update contents (read-before-write). The new contents are visible the next cycle.
- Counter at 2'b00 stays valid but predicts not-taken. There is no invalidation except CLR.
- Storage is in registers; no memory macro is required.

Optional Feature:
FETCH_PERF_EN:
- Defined:
  - FetchCount increments on each edge with CLR=0, Redirect=0, PCEn=1.
  - RedirectCount increments on each edge with CLR=0 and Redirect=1.
  - Both are 32-bit, wrap at 2^32, and reset to 0 on CLR.
- Undefined: both ports remain present and are driven constant 0; no counter flops are synthesized.

Test Plan:
- CLR=1 for 1 cycle, then PCEn=1 for 3 cycles, no updates -> PC sequence 0x3000, 0x3004, 0x3008, 0x300C; PredictJump=0 throughout.
- At PC=0x3008, PCEn=0 for 2 cycles -> PC holds 0x3008 and PC_plus_four holds 0x300C; PCEn=1 -> next PC 0x300C.
- Upd_Valid, Upd_PC=0x3010, Upd_Taken=1, Upd_Target=0x3400; later PC reaches 0x3010 -> PredictJump=1, PredictTarget=0x3400, next PC 0x3400.
- Two not-taken updates to 0x3010 (counter 10->01->00) -> PredictJump=0 at 0x3010; one taken update (00->01) -> still 0; a second taken update -> 1.
- Redirect=1, RedirectPC=0x3203, PCEn=0, while PredictJump=1 -> next PC 0x3200; with FETCH_PERF_EN, RedirectCount increments by 1 and FetchCount does not.
- CLR asserted together with Redirect and Upd_Valid mid-run -> PC=0x3000, all entries miss, PredictJump=0, perf counters 0.

Source files
------------

// File: rtl/fetch_pc_predictor.sv
// IF-stage PC register with a direct-mapped BTB of 2-bit saturating counters.
// Optional perf counters are built only when FETCH_PERF_EN is defined.
module fetch_pc_predictor #(
  parameter logic [31:0] RESET_PC     = 32'h0000_3000,
  parameter int          BTB_IDX_BITS = 4
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        PCEn,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  input  logic        Upd_Valid,
  input  logic [31:0] Upd_PC,
  input  logic        Upd_Taken,
  input  logic [31:0] Upd_Target,
  output logic [31:0] PC,
  output logic [31:0] PC_plus_four,
  output logic        PredictJump,
  output logic [31:0] PredictTarget,
  output logic [31:0] FetchCount,
  output logic [31:0] RedirectCount
);

  localparam int NUM_ENTRIES = 1 << BTB_IDX_BITS;
  localparam int TAG_W       = 30 - BTB_IDX_BITS;

  logic [NUM_ENTRIES-1:0]            btb_valid;
  logic [NUM_ENTRIES-1:0][TAG_W-1:0] btb_tag;
  logic [NUM_ENTRIES-1:0][29:0]      btb_target;
  logic [NUM_ENTRIES-1:0][1:0]       btb_ctr;

  logic [BTB_IDX_BITS-1:0] rd_idx;
  logic [TAG_W-1:0]        rd_tag;
  logic                    rd_hit;
  logic [BTB_IDX_BITS-1:0] wr_idx;
  logic [TAG_W-1:0]        wr_tag;
  logic                    wr_hit;
  logic [1:0]              wr_ctr;
  logic [1:0]              ctr_next;
  logic [31:0]             next_pc;
  logic                    unused_bits;

  // Instructions are word aligned, so the low two address bits never matter.
  assign unused_bits = ^{RedirectPC[1:0], Upd_PC[1:0], Upd_Target[1:0]};

  assign PC_plus_four = PC + 32'd4;

  // Lookup reads the registered contents, so a same-cycle update is seen next cycle.
  assign rd_idx        = PC[BTB_IDX_BITS+1:2];
  assign rd_tag        = PC[31:BTB_IDX_BITS+2];
  assign rd_hit        = btb_valid[rd_idx] && (btb_tag[rd_idx] == rd_tag);
  assign PredictJump   = rd_hit && btb_ctr[rd_idx][1];
  assign PredictTarget = rd_hit ? {btb_target[rd_idx], 2'b00} : 32'd0;

  assign wr_idx = Upd_PC[BTB_IDX_BITS+1:2];
  assign wr_tag = Upd_PC[31:BTB_IDX_BITS+2];
  assign wr_hit = btb_valid[wr_idx] && (btb_tag[wr_idx] == wr_tag);
  assign wr_ctr = btb_ctr[wr_idx];

  always_comb begin
    ctr_next = wr_ctr;
    if (Upd_Taken) begin
      if (wr_ctr != 2'b11) ctr_next = wr_ctr + 2'd1;
    end else begin
      if (wr_ctr != 2'b00) ctr_next = wr_ctr - 2'd1;
    end
  end

  // Timing contract: inputs are sampled on the rising edge of CLK; no handshake,
  // every cycle the outputs describe the fetch address currently held in PC.
  always_comb begin
    next_pc = PC;
    if (Redirect)  next_pc = {RedirectPC[31:2], 2'b00};
    else if (PCEn) next_pc = PredictJump ? PredictTarget : PC_plus_four;
  end

  always_ff @(posedge CLK) begin
    if (CLR) PC <= RESET_PC;
    else     PC <= next_pc;
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      btb_valid <= '0;
      btb_ctr   <= {NUM_ENTRIES{2'b01}};
    end else if (Upd_Valid) begin
      if (wr_hit) begin
        btb_ctr[wr_idx] <= ctr_next;
        if (Upd_Taken) btb_target[wr_idx] <= Upd_Target[31:2];
      end else if (Upd_Taken) begin
        btb_valid[wr_idx]  <= 1'b1;
        btb_tag[wr_idx]    <= wr_tag;
        btb_target[wr_idx] <= Upd_Target[31:2];
        btb_ctr[wr_idx]    <= 2'b10;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] redirect_count;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      fetch_count    <= '0;
      redirect_count <= '0;
    end else if (Redirect) begin
      redirect_count <= redirect_count + 32'd1;
    end else if (PCEn) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

  assign FetchCount    = fetch_count;
  assign RedirectCount = redirect_count;
`else
  assign FetchCount    = 32'd0;
  assign RedirectCount = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_pc_predictor.sv
// Bench for fetch_pc_predictor: directed walk of the fetch/BTB rules, then random
// traffic checked against a table-based reference model through an expected queue.
module tb_fetch_pc_predictor;

  localparam int          IB     = 4;
  localparam int          NE     = 1 << IB;
  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam int          W      = 161;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        pcen = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic [31:0] pc, pc_plus_four, predict_target, fetch_count, redirect_count;
  logic        predict_jump;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;

  // Reference model state: one record per BTB slot, plain integers.
  logic [31:0] m_pc;
  bit          m_valid[NE];
  logic [31:0] m_tag[NE];
  logic [31:0] m_target[NE];
  int          m_ctr[NE];
  logic [31:0] m_fc, m_rc;

  fetch_pc_predictor #(.RESET_PC(RST_PC), .BTB_IDX_BITS(IB)) dut (
    .CLK(clk), .CLR(clr), .PCEn(pcen), .Redirect(redirect), .RedirectPC(redirect_pc),
    .Upd_Valid(upd_valid), .Upd_PC(upd_pc), .Upd_Taken(upd_taken), .Upd_Target(upd_target),
    .PC(pc), .PC_plus_four(pc_plus_four), .PredictJump(predict_jump),
    .PredictTarget(predict_target), .FetchCount(fetch_count), .RedirectCount(redirect_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_lookup(input logic [31:0] a, output logic pj, output logic [31:0] pt);
    int i;
    bit hit;
    i   = int'((a >> 2) % NE);
    hit = m_valid[i] && (m_tag[i] == (a >> (IB + 2)));
    pj  = hit && (m_ctr[i] >= 2);
    pt  = hit ? m_target[i] : 32'd0;
  endfunction

  task automatic model_step(input bit c, input bit en, input bit rd, input logic [31:0] rpc,
                            input bit uv, input logic [31:0] upc, input bit ut,
                            input logic [31:0] utgt);
    logic        pj;
    logic [31:0] pt;
    logic [31:0] efc, erc;
    int          ui;
    m_lookup(m_pc, pj, pt);
    if (c) begin
      m_pc = RST_PC;
      for (int i = 0; i < NE; i++) begin
        m_valid[i] = 0;
        m_ctr[i]   = 1;
      end
      m_fc = 0;
      m_rc = 0;
    end else begin
      if (rd)       m_pc = rpc & ~32'd3;
      else if (en)  m_pc = pj ? pt : m_pc + 32'd4;
      if (rd)       m_rc = m_rc + 32'd1;
      else if (en)  m_fc = m_fc + 32'd1;
      if (uv) begin
        ui = int'((upc >> 2) % NE);
        if (m_valid[ui] && (m_tag[ui] == (upc >> (IB + 2)))) begin
          m_ctr[ui] = ut ? ((m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3)
                         : ((m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0);
          if (ut) m_target[ui] = utgt & ~32'd3;
        end else if (ut) begin
          m_valid[ui]  = 1;
          m_tag[ui]    = upc >> (IB + 2);
          m_target[ui] = utgt & ~32'd3;
          m_ctr[ui]    = 2;
        end
      end
    end
    m_lookup(m_pc, pj, pt);
`ifdef FETCH_PERF_EN
    efc = m_fc;
    erc = m_rc;
`else
    efc = 32'd0;
    erc = 32'd0;
`endif
    exp_q.push_back({m_pc, m_pc + 32'd4, pj, pt, efc, erc});
  endtask

  task automatic step(input bit c, input bit en, input bit rd, input logic [31:0] rpc,
                      input bit uv, input logic [31:0] upc, input bit ut,
                      input logic [31:0] utgt);
    @(negedge clk);
    clr = c; pcen = en; redirect = rd; redirect_pc = rpc;
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
    model_step(c, en, rd, rpc, uv, upc, ut, utgt);
    @(posedge clk);
    #1;
  endtask

  // Monitor: the DUT presents a new fetch state after every edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("pc",             pc,                     mon_e[160:129]);
        check("pc_plus_four",   pc_plus_four,           mon_e[128:97]);
        check("predict_jump",   {31'd0, predict_jump},  {31'd0, mon_e[96]});
        check("predict_target", predict_target,         mon_e[95:64]);
        check("fetch_count",    fetch_count,            mon_e[63:32]);
        check("redirect_count", redirect_count,         mon_e[31:0]);
      end
    end
  end

  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0);
    check("reset_pc", pc, 32'h3000);
    check("reset_pc4", pc_plus_four, 32'h3004);
    check("reset_pj", {31'd0, predict_jump}, 32'd0);

    step(0, 1, 0, 0, 0, 0, 0, 0);
    check("seq_3004", pc, 32'h3004);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    check("seq_3008", pc, 32'h3008);
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0);
      check("hold_pc", pc, 32'h3008);
      check("hold_pc4", pc_plus_four, 32'h300C);
    end
    step(0, 1, 0, 0, 0, 0, 0, 0);
    check("resume_300c", pc, 32'h300C);

    // Train 0x3010 as the PC moves onto it; the new entry is visible right after.
    step(0, 1, 0, 0, 1, 32'h3010, 1, 32'h3400);
    check("trained_pj", {31'd0, predict_jump}, 32'd1);
    check("trained_pt", predict_target, 32'h3400);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    check("predicted_pc", pc, 32'h3400);

    step(0, 0, 1, 32'h3010, 0, 0, 0, 0);
    check("redir_3010", pc, 32'h3010);
    step(0, 0, 0, 0, 1, 32'h3010, 0, 0);
    check("ctr_01_pj", {31'd0, predict_jump}, 32'd0);
    step(0, 0, 0, 0, 1, 32'h3010, 0, 0);
    check("ctr_00_pj", {31'd0, predict_jump}, 32'd0);
    step(0, 0, 0, 0, 1, 32'h3010, 1, 32'h3400);
    check("ctr_01b_pj", {31'd0, predict_jump}, 32'd0);
    step(0, 0, 0, 0, 1, 32'h3010, 1, 32'h3400);
    check("ctr_10_pj", {31'd0, predict_jump}, 32'd1);

    step(0, 0, 1, 32'h3203, 0, 0, 0, 0);
    check("redir_over_pred", pc, 32'h3200);

    step(0, 0, 1, 32'hFFFF_FFFE, 0, 0, 0, 0);
    check("top_pc", pc, 32'hFFFF_FFFC);
    check("wrap_pc4", pc_plus_four, 32'h0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    check("wrap_pc", pc, 32'h0);

    // CLR must beat a simultaneous redirect and update.
    step(0, 0, 1, 32'h3000, 1, 32'h3000, 1, 32'h3100);
    check("pre_clr_pj", {31'd0, predict_jump}, 32'd1);
    step(1, 1, 1, 32'h3100, 1, 32'h3000, 1, 32'h3100);
    check("clr_pc", pc, 32'h3000);
    check("clr_pj", {31'd0, predict_jump}, 32'd0);
    check("clr_pt", predict_target, 32'd0);
    step(0, 0, 1, 32'h3010, 0, 0, 0, 0);
    check("clr_miss_3010", {31'd0, predict_jump}, 32'd0);

    for (int n = 0; n < 1500; n++) begin
      step($urandom_range(0, 99) < 1,
           $urandom_range(0, 99) < 75,
           $urandom_range(0, 99) < 10,
           32'h3000 + $urandom_range(0, 255),
           $urandom_range(0, 99) < 40,
           32'h3000 + 4 * $urandom_range(0, 63),
           $urandom_range(0, 99) < 60,
           32'h3000 + $urandom_range(0, 255));
    end

    @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
